tt_slot_mux: RTL and testbench

- Parametrised successor to the single-project slot wrapper. Hosts N_PROJ user-project slots behind one set of pad signals.
- Each slot keeps the packed bus layout:
  - iw = {uio_in[7:0], ui_in[7:0], rst_n, clk}, 18 bits.
  - ow = {uio_oe[7:0], uio_out[7:0], uo_out[7:0]}, 24 bits.
- Adds runtime project selection with a safe switch sequence: isolate, then reset-hold, then run. Pad outputs are registered.
- Sits between the chip pad ring and the per-slot project wrappers. Slots are instantiated outside this block.

---
 rtl/tt_slot_mux_pkg.sv | 32 +++
 rtl/tt_slot_seq.sv | 93 +++++++++
 rtl/tt_slot_mux.sv | 111 +++++++++++
 tb/tb_tt_slot_mux.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_slot_mux_pkg.sv
// ---------------------------------------------------------------------------
// tt_slot_mux_pkg
// Shared types and constants for the multi-slot project mux.
//   state_e     : sequencer states (RESET / RUN / ISOLATE)
//   IW_*        : bit offsets inside a slot's 18-bit packed input bus
//   OW_*        : bit offsets inside a slot's 24-bit packed output bus
//   max_int     : constant helper used to size the shared counter
// ---------------------------------------------------------------------------
package tt_slot_mux_pkg;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_RUN     = 2'd1,
        ST_ISOLATE = 2'd2
    } state_e;

    // iw = {uio_in[7:0], ui_in[7:0], rst_n, clk}
    localparam int IW_CLK  = 0;
    localparam int IW_RSTN = 1;
    localparam int IW_UI   = 2;
    localparam int IW_UIO  = 10;

    // ow = {uio_oe[7:0], uio_out[7:0], uo_out[7:0]}
    localparam int OW_UO   = 0;
    localparam int OW_UIO  = 8;
    localparam int OW_OE   = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tt_slot_seq.sv
// ---------------------------------------------------------------------------
// tt_slot_seq
// Selection sequencer: owns the state machine, the shared isolate/reset-hold
// counter, the select handshake and the cur_sel / target registers.
//   clk, rst       : clock, synchronous active-high reset
//   sel_valid_i    : selection request (honoured only in RUN)
//   sel_idx_i      : requested slot index
//   state_o        : current state (registered)
//   cur_sel_o      : slot that is being reset or is running
//   sel_err_o      : one-cycle pulse after an out-of-range request
// ---------------------------------------------------------------------------
module tt_slot_seq
    import tt_slot_mux_pkg::*;
#(
    parameter int N_PROJ     = 4,
    parameter int ISO_CYCLES = 2,
    parameter int RST_HOLD   = 8,
    parameter int SEL_W      = $clog2(N_PROJ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel_valid_i,
    input  logic [SEL_W-1:0] sel_idx_i,
    output state_e           state_o,
    output logic [SEL_W-1:0] cur_sel_o,
    output logic             sel_err_o
);

    // One counter serves both timed states; sized so the larger load fits.
    localparam int CNT_W = $clog2(max_int(ISO_CYCLES, RST_HOLD) + 1);

    state_e           state_q;
    logic [SEL_W-1:0] cur_sel_q;
    logic [SEL_W-1:0] target_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sel_err_q;
    logic             in_range;

    // With a power-of-two slot count every index is legal and this folds away.
    assign in_range = (32'(sel_idx_i) < N_PROJ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RESET;
            cur_sel_q <= '0;
            target_q  <= '0;
            cnt_q     <= CNT_W'(RST_HOLD - 1);
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= 1'b0;
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (sel_valid_i) begin
                        if (in_range) begin
                            // Re-selecting the running slot is legal and
                            // simply re-runs the isolate/reset sequence.
                            target_q <= sel_idx_i;
                            state_q  <= ST_ISOLATE;
                            cnt_q    <= CNT_W'(ISO_CYCLES - 1);
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end
                end
                ST_ISOLATE: begin
                    if (cnt_q == '0) begin
                        cur_sel_q <= target_q;
                        state_q   <= ST_RESET;
                        cnt_q     <= CNT_W'(RST_HOLD - 1);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_RESET;
                    cnt_q   <= CNT_W'(RST_HOLD - 1);
                end
            endcase
        end
    end

    assign state_o   = state_q;
    assign cur_sel_o = cur_sel_q;
    assign sel_err_o = sel_err_q;

endmodule

// File: rtl/tt_slot_mux.sv
// ---------------------------------------------------------------------------
// tt_slot_mux
// Hosts N_PROJ project slots behind one pad interface. Runtime selection
// walks isolate -> reset-hold -> run so a new project never sees a partial
// switch. Pad outputs are registered and forced to zero outside RUN, which
// also keeps every bidir pad tristated while switching.
//   clk, rst               : clock (also forwarded to slots), sync reset
//   pad_rst_n              : user reset, forwarded to the running slot
//   ui_in, uio_in          : pad inputs, fanned out to the active slot
//   uo_out/uio_out/uio_oe  : registered pad outputs from the active slot
//   sel_valid/sel_idx      : selection request; sel_ready high in RUN
//   sel_err                : pulse for an out-of-range request
//   cur_sel, busy          : active slot, switch in progress
//   ena_out                : per-slot enable, one-hot or zero
//   iw_out / ow_in         : per-slot packed buses, slot k at [k*W +: W]
// ---------------------------------------------------------------------------
module tt_slot_mux
    import tt_slot_mux_pkg::*;
#(
    parameter int N_PROJ     = 4,
    parameter int IW_W       = 18,
    parameter int OW_W       = 24,
    parameter int ISO_CYCLES = 2,
    parameter int RST_HOLD   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pad_rst_n,
    input  logic [7:0]                 ui_in,
    input  logic [7:0]                 uio_in,
    output logic [7:0]                 uo_out,
    output logic [7:0]                 uio_out,
    output logic [7:0]                 uio_oe,
    input  logic                       sel_valid,
    input  logic [$clog2(N_PROJ)-1:0]  sel_idx,
    output logic                       sel_ready,
    output logic                       sel_err,
    output logic [$clog2(N_PROJ)-1:0]  cur_sel,
    output logic                       busy,
    output logic [N_PROJ-1:0]          ena_out,
    output logic [N_PROJ*IW_W-1:0]     iw_out,
    input  logic [N_PROJ*OW_W-1:0]     ow_in
);

    localparam int SEL_W = $clog2(N_PROJ);

    state_e           state;
    logic [SEL_W-1:0] cur_sel_w;
    logic [OW_W-1:0]  ow_d;
    logic [OW_W-1:0]  ow_q;

    tt_slot_seq #(
        .N_PROJ     (N_PROJ),
        .ISO_CYCLES (ISO_CYCLES),
        .RST_HOLD   (RST_HOLD),
        .SEL_W      (SEL_W)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .sel_valid_i (sel_valid),
        .sel_idx_i   (sel_idx),
        .state_o     (state),
        .cur_sel_o   (cur_sel_w),
        .sel_err_o   (sel_err)
    );

    assign cur_sel   = cur_sel_w;
    assign sel_ready = (state == ST_RUN);
    assign busy      = (state != ST_RUN);

    // Input fan-out. Every slot always receives clk; only the active slot
    // sees pad data, and its rst_n is held low until the sequencer hits RUN.
    genvar gi;
    generate
        for (gi = 0; gi < N_PROJ; gi++) begin : g_slot
            logic active;
            assign active      = (state != ST_ISOLATE) && (cur_sel_w == SEL_W'(gi));
            assign ena_out[gi] = active;

            assign iw_out[gi*IW_W + IW_CLK]       = clk;
            assign iw_out[gi*IW_W + IW_RSTN]      = active && (state == ST_RUN) && pad_rst_n;
            assign iw_out[gi*IW_W + IW_UI  +: 8]  = active ? ui_in  : 8'h00;
            assign iw_out[gi*IW_W + IW_UIO +: 8]  = active ? uio_in : 8'h00;
        end
    endgenerate

    // Output mux: only the running slot may drive the pads.
    always_comb begin
        ow_d = '0;
        if (state == ST_RUN) begin
            for (int k = 0; k < N_PROJ; k++) begin
                if (cur_sel_w == SEL_W'(k)) begin
                    ow_d = ow_in[k*OW_W +: OW_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ow_q <= '0;
        end else begin
            ow_q <= ow_d;
        end
    end

    assign uo_out  = ow_q[OW_UO  +: 8];
    assign uio_out = ow_q[OW_UIO +: 8];
    assign uio_oe  = ow_q[OW_OE  +: 8];

endmodule

// File: tb/tb_tt_slot_mux.sv
// ---------------------------------------------------------------------------
// tb_tt_slot_mux
// Main instance: 4 slots. Second instance: 3 slots, so index 3 is illegal.
// The stimulus process pushes cycle-tagged expectations into a scoreboard
// queue; a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_tt_slot_mux;

    localparam int N    = 4;
    localparam int NE   = 3;
    localparam int IW_W = 18;
    localparam int OW_W = 24;

    typedef enum int {
        K_ENA, K_BUSY, K_READY, K_CUR, K_RSTN, K_UIA, K_OUT,
        K_EERR, K_EENA, K_EBUSY
    } kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    logic pad_rst_n;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic sel_valid;
    logic [1:0] sel_idx;
    logic sel_ready, sel_err, busy;
    logic [1:0] cur_sel;
    logic [N-1:0] ena_out;
    logic [N*IW_W-1:0] iw_out;
    logic [N*OW_W-1:0] ow_in;

    logic sel_valid_e;
    logic [1:0] sel_idx_e;
    logic [7:0] uo_out_e, uio_out_e, uio_oe_e;
    logic sel_ready_e, sel_err_e, busy_e;
    logic [1:0] cur_sel_e;
    logic [NE-1:0] ena_out_e;
    logic [NE*IW_W-1:0] iw_out_e;
    logic [NE*OW_W-1:0] ow_in_e;

    logic [23:0] ow_tab [4];

    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    exp_t keep_q[$];

    tt_slot_mux #(.N_PROJ(N), .IW_W(IW_W), .OW_W(OW_W), .ISO_CYCLES(2), .RST_HOLD(8)) dut (
        .clk(clk), .rst(rst), .pad_rst_n(pad_rst_n), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_ready(sel_ready), .sel_err(sel_err),
        .cur_sel(cur_sel), .busy(busy), .ena_out(ena_out), .iw_out(iw_out), .ow_in(ow_in)
    );

    tt_slot_mux #(.N_PROJ(NE), .IW_W(IW_W), .OW_W(OW_W), .ISO_CYCLES(2), .RST_HOLD(8)) dut_e (
        .clk(clk), .rst(rst), .pad_rst_n(pad_rst_n), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out_e), .uio_out(uio_out_e), .uio_oe(uio_oe_e),
        .sel_valid(sel_valid_e), .sel_idx(sel_idx_e), .sel_ready(sel_ready_e), .sel_err(sel_err_e),
        .cur_sel(cur_sel_e), .busy(busy_e), .ena_out(ena_out_e), .iw_out(iw_out_e), .ow_in(ow_in_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign ow_in   = {ow_tab[3], ow_tab[2], ow_tab[1], ow_tab[0]};
    assign ow_in_e = {ow_tab[2], ow_tab[1], ow_tab[0]};

    function automatic logic [31:0] observe(input kind_e k);
        logic [31:0] r;
        r = '0;
        case (k)
            K_ENA:   r = 32'(ena_out);
            K_BUSY:  r = 32'(busy);
            K_READY: r = 32'(sel_ready);
            K_CUR:   r = 32'(cur_sel);
            K_RSTN:  for (int i = 0; i < N; i++) r[i] = iw_out[i*IW_W + 1];
            K_UIA:   for (int i = 0; i < N; i++) r[i*8 +: 8] = iw_out[i*IW_W + 2 +: 8];
            K_OUT:   r = {8'h00, uio_oe, uio_out, uo_out};
            K_EERR:  r = 32'(sel_err_e);
            K_EENA:  r = 32'(ena_out_e);
            K_EBUSY: r = 32'(busy_e);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        logic [31:0] got;
        keep_q.delete();
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                n_checks++;
                got = observe(sb[i].kind);
                if (got !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", sb[i].name, cyc, got, sb[i].val);
                end
            end else if (sb[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s cyc=%0d expectation expired unchecked", sb[i].name, sb[i].cyc);
            end else begin
                keep_q.push_back(sb[i]);
            end
        end
        sb = keep_q;
    end

    task automatic push(input int c, input kind_e k, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Full snapshot of the main instance for one cycle.
    task automatic exp_snap(input int c, input logic [31:0] ena, input logic b, input int cur,
                            input logic [31:0] rstn, input logic [31:0] ui, input logic [31:0] out,
                            input string tag);
        push(c, K_ENA,   ena,        {tag, "_ena"});
        push(c, K_BUSY,  32'(b),     {tag, "_busy"});
        push(c, K_READY, 32'(!b),    {tag, "_ready"});
        push(c, K_CUR,   32'(cur),   {tag, "_cur"});
        push(c, K_RSTN,  rstn,       {tag, "_rstn"});
        push(c, K_UIA,   ui,         {tag, "_ui"});
        push(c, K_OUT,   out,        {tag, "_out"});
    endtask

    function automatic logic [31:0] ui_for(input int k);
        return 32'h11 << (8 * k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    // Switch from slot prev to idx; with poke, keep issuing a different
    // request throughout the busy window, which must be ignored.
    task automatic switch_seq(input int idx, input int prev, input bit poke);
        int s;
        s = cyc;
        $display("switch request: slot %0d -> slot %0d at cycle %0d", prev, idx, s);
        exp_snap(s + 1, 0, 1'b1, prev, 0, 0, 32'(ow_tab[prev]), "iso_first");
        exp_snap(s + 2, 0, 1'b1, prev, 0, 0, 0, "iso_last");
        for (int c = s + 3; c <= s + 10; c++)
            exp_snap(c, 32'(1) << idx, 1'b1, idx, 0, ui_for(idx), 0, "hold");
        exp_snap(s + 11, 32'(1) << idx, 1'b0, idx, 32'(1) << idx, ui_for(idx), 0, "run_first");
        push(s + 12, K_OUT, 32'(ow_tab[idx]), "run_data");
        sel_valid = 1'b1;
        sel_idx   = 2'(idx);
        tick();
        if (poke) begin
            sel_idx = 2'((idx + 1) % N);
            repeat (8) tick();
        end
        sel_valid = 1'b0;
        wait_to(s + 12);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        n_checks    = 0;
        n_fail      = 0;
        ow_tab[0]   = 24'hA5_3C_81;
        ow_tab[1]   = 24'h1E_2D_3C;
        ow_tab[2]   = 24'h5A_69_78;
        ow_tab[3]   = 24'hC3_D2_E1;
        rst         = 1'b1;
        pad_rst_n   = 1'b1;
        ui_in       = 8'h11;
        uio_in      = 8'h22;
        sel_valid   = 1'b0;
        sel_idx     = 2'd0;
        sel_valid_e = 1'b0;
        sel_idx_e   = 2'd0;

        // Reset release: 8 hold cycles on slot 0, then RUN, data one cycle later.
        repeat (3) tick();
        rst = 1'b0;
        $display("reset released at cycle %0d", cyc);
        for (int c = 3; c <= 10; c++)
            exp_snap(c, 32'h1, 1'b1, 0, 0, ui_for(0), 0, "rst_hold");
        exp_snap(11, 32'h1, 1'b0, 0, 32'h1, ui_for(0), 0, "rst_run_first");
        push(12, K_OUT, 32'(ow_tab[0]), "rst_run_data");
        push(3,  K_EERR,  0, "e_err_reset");
        push(11, K_EBUSY, 0, "e_busy_run");
        push(11, K_EENA,  1, "e_ena_run");
        wait_to(12);

        // Out-of-range index on the 3-slot instance.
        $display("out-of-range request idx=3 on 3-slot instance at cycle %0d", cyc);
        push(13, K_EERR,  1, "e_err_pulse");
        push(13, K_EENA,  1, "e_ena_kept");
        push(13, K_EBUSY, 0, "e_no_busy");
        push(14, K_EERR,  0, "e_err_clear");
        push(14, K_EBUSY, 0, "e_still_run");
        sel_valid_e = 1'b1;
        sel_idx_e   = 2'd3;
        tick();
        sel_valid_e = 1'b0;
        wait_to(14);

        // Switch to slot 2 with requests hammered during busy.
        switch_seq(2, 0, 1'b1);

        // pad_rst_n passthrough on the running slot.
        $display("pad_rst_n toggle at cycle %0d", cyc);
        pad_rst_n = 1'b0;
        #1;
        push(cyc, K_RSTN, 32'h0, "pad_rstn_low");
        tick();
        pad_rst_n = 1'b1;
        #1;
        push(cyc, K_RSTN, 32'h4, "pad_rstn_high");
        push(cyc, K_UIA, ui_for(2), "pad_ui_slot2");
        tick();

        // Switch to slot 1, then re-select slot 1.
        switch_seq(1, 2, 1'b0);
        switch_seq(1, 1, 1'b0);

        // Reset in the middle of a switch toward slot 3.
        s = cyc;
        $display("switch to slot 3 interrupted by reset at cycle %0d", s);
        exp_snap(s + 1, 0, 1'b1, 1, 0, 0, 32'(ow_tab[1]), "mid_iso");
        for (int c = s + 2; c <= s + 9; c++)
            exp_snap(c, 32'h1, 1'b1, 0, 0, ui_for(0), 0, "mid_rst_hold");
        exp_snap(s + 10, 32'h1, 1'b0, 0, 32'h1, ui_for(0), 0, "mid_run_first");
        push(s + 11, K_OUT, 32'(ow_tab[0]), "mid_run_data");
        sel_valid = 1'b1;
        sel_idx   = 2'd3;
        tick();
        sel_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        wait_to(s + 11);
        tick();
        tick();

        foreach (sb[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s cyc=%0d never checked", sb[i].name, sb[i].cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
